// File: rtl/alu_pkg.sv
// Shared ALU op encoding used by the arbiter, the ALU and anything that issues requests.
package alu_pkg;

    typedef enum logic [3:0] {
        A_ADD  = 4'b0000,
        A_SUB  = 4'b1000,
        A_XOR  = 4'b0100,
        A_OR   = 4'b0110,
        A_AND  = 4'b0111,
        A_SLL  = 4'b0001,
        A_SRL  = 4'b0101,
        A_SRA  = 4'b1101,
        A_SLT  = 4'b0010,
        A_SLTU = 4'b0011
    } alu_op_e;

endpackage

// File: rtl/alu.sv
// Purely combinational ALU; o_insn_vld drops for any op code outside alu_op_e.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_res,
    output logic             o_insn_vld
);

    localparam int SH_W = $clog2(WIDTH);

    logic [SH_W-1:0] sh;

    assign sh = i_b[SH_W-1:0];

    always_comb begin
        o_res      = '0;
        o_insn_vld = 1'b1;
        case (i_op)
            A_ADD:   o_res = i_a + i_b;
            A_SUB:   o_res = i_a - i_b;
            A_XOR:   o_res = i_a ^ i_b;
            A_OR:    o_res = i_a | i_b;
            A_AND:   o_res = i_a & i_b;
            A_SLL:   o_res = i_a << sh;
            A_SRL:   o_res = i_a >> sh;
            A_SRA:   o_res = $unsigned($signed(i_a) >>> sh);
            A_SLT:   o_res = {{(WIDTH-1){1'b0}}, $signed(i_a) < $signed(i_b)};
            A_SLTU:  o_res = {{(WIDTH-1){1'b0}}, i_a < i_b};
            default: o_insn_vld = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU; the winner's result lands in a one-entry output register.
// ALU_ARB_RR_EN selects round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [1:0]           i_req_valid,
    output logic [1:0]           o_req_ready,
    input  logic [7:0]           i_req_op,
    input  logic [2*WIDTH-1:0]   i_req_a,
    input  logic [2*WIDTH-1:0]   i_req_b,
    input  logic [2*TAG_W-1:0]   i_req_tag,
    output logic                 o_res_valid,
    input  logic                 i_res_ready,
    output logic [WIDTH-1:0]     o_res_data,
    output logic                 o_res_insn_vld,
    output logic                 o_res_src,
    output logic [TAG_W-1:0]     o_res_tag
);

    logic             can_accept;
    logic             win;
    logic             xfer;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [TAG_W-1:0] sel_tag;
    logic [WIDTH-1:0] alu_res;
    logic             alu_iv;

    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q,  res_data_d;
    logic             res_iv_q,    res_iv_d;
    logic             res_src_q,   res_src_d;
    logic [TAG_W-1:0] res_tag_q,   res_tag_d;

`ifdef ALU_ARB_RR_EN
    logic lrg_q, lrg_d;

    // Contention goes to whoever was not granted last; a lone requester always wins.
    always_comb begin
        win   = (i_req_valid == 2'b11) ? ~lrg_q : ~i_req_valid[0];
        lrg_d = xfer ? win : lrg_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) lrg_q <= 1'b1;
        else       lrg_q <= lrg_d;
    end
`else
    always_comb win = ~i_req_valid[0];
`endif

    // Ready depends only on valids and output-stage state, never on payload.
    always_comb begin
        can_accept  = !res_valid_q || i_res_ready;
        o_req_ready = 2'b00;
        if (can_accept && (|i_req_valid) && !i_rst) o_req_ready[win] = 1'b1;
        xfer = |(i_req_valid & o_req_ready);
    end

    always_comb begin
        alu_op  = win ? i_req_op[7:4]              : i_req_op[3:0];
        alu_a   = win ? i_req_a[2*WIDTH-1:WIDTH]   : i_req_a[WIDTH-1:0];
        alu_b   = win ? i_req_b[2*WIDTH-1:WIDTH]   : i_req_b[WIDTH-1:0];
        sel_tag = win ? i_req_tag[2*TAG_W-1:TAG_W] : i_req_tag[TAG_W-1:0];
    end

    alu #(.WIDTH(WIDTH)) u_alu (
        .i_op       (alu_op),
        .i_a        (alu_a),
        .i_b        (alu_b),
        .o_res      (alu_res),
        .o_insn_vld (alu_iv)
    );

    always_comb begin
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_iv_d    = res_iv_q;
        res_src_d   = res_src_q;
        res_tag_d   = res_tag_q;
        if (xfer) begin
            res_valid_d = 1'b1;
            res_data_d  = alu_res;
            res_iv_d    = alu_iv;
            res_src_d   = win;
            res_tag_d   = sel_tag;
        end else if (res_valid_q && i_res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_iv_q    <= 1'b0;
            res_src_q   <= 1'b0;
            res_tag_q   <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_iv_q    <= res_iv_d;
            res_src_q   <= res_src_d;
            res_tag_q   <= res_tag_d;
        end
    end

    assign o_res_valid    = res_valid_q;
    assign o_res_data     = res_data_q;
    assign o_res_insn_vld = res_iv_q;
    assign o_res_src      = res_src_q;
    assign o_res_tag      = res_tag_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_alu_arbiter;
    import alu_pkg::*;

`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [7:0]  req_tag;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_iv;
    logic        res_src;
    logic [3:0]  res_tag;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model of the output stage and arbitration history
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_dchk;
    logic        m_iv;
    logic        m_src;
    logic [3:0]  m_tag;
    int          m_last;

    alu_arbiter #(.WIDTH(32), .TAG_W(4)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_op       (req_op),
        .i_req_a        (req_a),
        .i_req_b        (req_b),
        .i_req_tag      (req_tag),
        .o_res_valid    (res_valid),
        .i_res_ready    (res_ready),
        .o_res_data     (res_data),
        .o_res_insn_vld (res_iv),
        .o_res_src      (res_src),
        .o_res_tag      (res_tag)
    );

    always #5 clk = ~clk;

    function automatic bit ref_legal(logic [3:0] op);
        return op inside {A_ADD, A_SUB, A_XOR, A_OR, A_AND, A_SLL, A_SRL, A_SRA, A_SLT, A_SLTU};
    endfunction

    function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        int sh = int'(b % 32);
        logic [31:0] fill = (a[31] && sh != 0) ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
        case (op)
            A_ADD:   return a + b;
            A_SUB:   return a + ~b + 32'd1;
            A_XOR:   return a ^ b;
            A_OR:    return a | b;
            A_AND:   return a & b;
            A_SLL:   return a << sh;
            A_SRL:   return a >> sh;
            A_SRA:   return (a >> sh) | fill;
            A_SLT:   return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            A_SLTU:  return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Which requester the specification says should be granted right now (bit mask).
    function automatic logic [1:0] exp_ready();
        int w;
        if (rst || req_valid == 2'b00 || (m_valid && !res_ready)) return 2'b00;
        if (req_valid == 2'b11) w = RR ? (1 - m_last) : 0;
        else                    w = req_valid[0] ? 0 : 1;
        return (w == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic model_apply();
        logic [1:0] g;
        int w;
        g = exp_ready();
        if (rst) begin
            m_valid = 0; m_data = 0; m_dchk = 1; m_iv = 0; m_src = 0; m_tag = 0; m_last = 1;
        end else if (g != 2'b00) begin
            w       = g[1] ? 1 : 0;
            m_valid = 1;
            m_iv    = ref_legal(req_op[w*4 +: 4]);
            m_dchk  = m_iv;
            m_data  = ref_alu(req_op[w*4 +: 4], req_a[w*32 +: 32], req_b[w*32 +: 32]);
            m_src   = w[0];
            m_tag   = req_tag[w*4 +: 4];
            m_last  = w;
        end else if (m_valid && res_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic step();
        model_apply();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int j, logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [3:0] tag);
        req_op[j*4 +: 4]   = op;
        req_a[j*32 +: 32]  = a;
        req_b[j*32 +: 32]  = b;
        req_tag[j*4 +: 4]  = tag;
    endtask

    task automatic do_reset();
        rst = 1; req_valid = 2'b00; res_ready = 1;
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; req_valid = 2'b11; res_ready = 1;
        set_req(0, A_ADD, 1, 2, 1); set_req(1, A_ADD, 3, 4, 2);
        #1;
        n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_ready got=%b exp=00", req_ready); end
        step();
        n_cmp++;
        if (res_valid !== 0 || res_data !== 0 || res_iv !== 0 || res_src !== 0 || res_tag !== 0) begin
            n_fail++;
            $display("FAIL rst_outputs got v=%b d=%h iv=%b s=%b t=%h exp all 0", res_valid, res_data, res_iv, res_src, res_tag);
        end
        rst = 0; req_valid = 2'b00;
    endtask

    task automatic test_req0_add();
        set_req(0, A_ADD, 5, 7, 3);
        req_valid = 2'b01; res_ready = 1;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL add_ready got=%b exp=01", req_ready); end
        step();
        req_valid = 2'b00;
        n_cmp++;
        if (res_valid !== 1 || res_data !== 32'd12 || res_src !== 0 || res_tag !== 4'd3 || res_iv !== 1) begin
            n_fail++;
            $display("FAIL add_result got v=%b d=%0d s=%b t=%0d iv=%b exp v=1 d=12 s=0 t=3 iv=1", res_valid, res_data, res_src, res_tag, res_iv);
        end
    endtask

    task automatic test_req1_sra_sltu();
        set_req(1, A_SRA, 32'hFFFF_FFFC, 1, 9);
        req_valid = 2'b10; res_ready = 1;
        #1;
        n_cmp++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL sra_ready got=%b exp=10", req_ready); end
        step();
        n_cmp++;
        if (res_data !== 32'hFFFF_FFFE || res_src !== 1 || res_tag !== 4'd9) begin
            n_fail++;
            $display("FAIL sra_result got d=%h s=%b t=%0d exp d=fffffffe s=1 t=9", res_data, res_src, res_tag);
        end
        set_req(1, A_SLTU, 32'hFFFF_FFFC, 1, 10);
        step();
        req_valid = 2'b00;
        n_cmp++;
        if (res_data !== 32'd0 || res_src !== 1 || res_tag !== 4'd10 || res_valid !== 1) begin
            n_fail++;
            $display("FAIL sltu_result got d=%h s=%b t=%0d v=%b exp d=0 s=1 t=10 v=1", res_data, res_src, res_tag, res_valid);
        end
    endtask

    task automatic test_contention();
        logic [1:0]  er;
        logic        es;
        logic [31:0] ed;
        do_reset();
        set_req(0, A_SUB, 10, 3, 1);
        set_req(1, A_XOR, 32'hF0, 32'hFF, 2);
        req_valid = 2'b11; res_ready = 1;
        for (int i = 0; i < 4; i++) begin
            es = RR ? i[0] : 1'b0;
            er = es ? 2'b10 : 2'b01;
            ed = es ? 32'h0F : 32'd7;
            #1;
            n_cmp++; if (req_ready !== er) begin n_fail++; $display("FAIL cont_ready[%0d] got=%b exp=%b", i, req_ready, er); end
            step();
            n_cmp++;
            if (res_src !== es || res_data !== ed || res_valid !== 1) begin
                n_fail++;
                $display("FAIL cont_result[%0d] got s=%b d=%h v=%b exp s=%b d=%h v=1", i, res_src, res_data, res_valid, es, ed);
            end
        end
        req_valid = 2'b00;
        step();
    endtask

    task automatic test_backpressure();
        logic [31:0] d0;
        logic [1:0]  er;
        do_reset();
        set_req(0, A_SUB, 10, 3, 4);
        set_req(1, A_XOR, 32'hF0, 32'hFF, 5);
        req_valid = 2'b11; res_ready = 1;
        step();
        d0 = res_data;
        n_cmp++; if (res_src !== 0 || d0 !== 32'd7) begin n_fail++; $display("FAIL bp_first got s=%b d=%h exp s=0 d=7", res_src, d0); end
        res_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_ready[%0d] got=%b exp=00", i, req_ready); end
            step();
            n_cmp++;
            if (res_valid !== 1 || res_data !== d0 || res_src !== 0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d] got v=%b d=%h s=%b exp v=1 d=%h s=0", i, res_valid, res_data, res_src, d0);
            end
        end
        res_ready = 1;
        er = RR ? 2'b10 : 2'b01;
        #1;
        n_cmp++; if (req_ready !== er) begin n_fail++; $display("FAIL bp_release got=%b exp=%b", req_ready, er); end
        step();
        n_cmp++; if (res_src !== er[1]) begin n_fail++; $display("FAIL bp_next_src got=%b exp=%b", res_src, er[1]); end
        req_valid = 2'b00;
        step();
    endtask

    task automatic test_illegal();
        set_req(0, 4'b1111, 32'h1234, 32'h5678, 6);
        req_valid = 2'b01; res_ready = 1;
        step();
        req_valid = 2'b00;
        n_cmp++;
        if (res_iv !== 0 || res_src !== 0 || res_valid !== 1 || res_tag !== 4'd6) begin
            n_fail++;
            $display("FAIL illegal got iv=%b s=%b v=%b t=%0d exp iv=0 s=0 v=1 t=6", res_iv, res_src, res_valid, res_tag);
        end
    endtask

    task automatic test_reset_mid();
        set_req(0, A_ADD, 100, 23, 7);
        set_req(1, A_OR, 32'h10, 32'h01, 8);
        req_valid = 2'b10; res_ready = 0;
        step();
        n_cmp++; if (res_valid !== 1) begin n_fail++; $display("FAIL midrst_pre got v=%b exp=1", res_valid); end
        rst = 1; req_valid = 2'b11; res_ready = 1;
        #1;
        n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL midrst_ready got=%b exp=00", req_ready); end
        step();
        rst = 0;
        n_cmp++;
        if (res_valid !== 0 || res_data !== 0 || res_iv !== 0 || res_src !== 0 || res_tag !== 0) begin
            n_fail++;
            $display("FAIL midrst_outputs got v=%b d=%h iv=%b s=%b t=%h exp all 0", res_valid, res_data, res_iv, res_src, res_tag);
        end
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL midrst_first got=%b exp=01", req_ready); end
        step();
        n_cmp++; if (res_src !== 0 || res_data !== 32'd123) begin n_fail++; $display("FAIL midrst_win got s=%b d=%0d exp s=0 d=123", res_src, res_data); end
        req_valid = 2'b00;
        step();
    endtask

    function automatic logic [31:0] rnd_operand();
        logic [31:0] edges [5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        if ($urandom_range(3) == 0) return edges[$urandom_range(4)];
        return $urandom;
    endfunction

    function automatic logic [3:0] rnd_op();
        logic [3:0] ops [10] = '{A_ADD, A_SUB, A_XOR, A_OR, A_AND, A_SLL, A_SRL, A_SRA, A_SLT, A_SLTU};
        if ($urandom_range(7) == 0) return 4'($urandom);
        return ops[$urandom_range(9)];
    endfunction

    task automatic test_random();
        logic [1:0] er;
        int bad;
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(59) == 0);
            req_valid = 2'($urandom);
            res_ready = ($urandom_range(3) != 0);
            for (int j = 0; j < 2; j++) set_req(j, rnd_op(), rnd_operand(), rnd_operand(), 4'($urandom));
            #1;
            er = exp_ready();
            n_cmp++; if (req_ready !== er) begin n_fail++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", i, req_ready, er); end
            step();
            bad = (res_valid !== m_valid) || (res_iv !== m_iv) || (res_src !== m_src) ||
                  (res_tag !== m_tag) || (m_dchk && res_data !== m_data);
            n_cmp++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL rnd_out[%0d] got v=%b d=%h iv=%b s=%b t=%h exp v=%b d=%h iv=%b s=%b t=%h",
                         i, res_valid, res_data, res_iv, res_src, res_tag, m_valid, m_data, m_iv, m_src, m_tag);
            end
        end
        rst = 0; req_valid = 2'b00; res_ready = 1;
        step();
    endtask

    initial begin
        rst = 1; req_valid = 0; res_ready = 1; req_op = 0; req_a = 0; req_b = 0; req_tag = 0;
        m_valid = 0; m_data = 0; m_dchk = 1; m_iv = 0; m_src = 0; m_tag = 0; m_last = 1;
        @(negedge clk);
        test_reset();
        test_req0_add();
        test_req1_sra_sltu();
        test_contention();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
